cnn_layer_sequencer: RTL

- Top-level controller for the two-layer image pipeline: 3x3 convolution with ReLU into layer-0 memory, then 2x2 max-pool into layer-1 memory.
- Accepts the host ready/busy handshake and starts the convolution engine, then the pooling engine.
- Owns the single shared layer-memory port: muxes each engine's read/write strobes onto it and drives csel.
- Filters spurious writes and guards each phase with a watchdog.

---
 rtl/cnn_pkg.sv | 18 +
 rtl/cnn_mem_port_mux.sv | 59 +++++
 rtl/cnn_layer_sequencer.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/cnn_pkg.sv
// Shared types and constants for the two-layer CNN sequencer.
package cnn_pkg;
    localparam int ADDR_W = 12;
    localparam int DATA_W = 20;

    localparam logic [2:0] CSEL_L0   = 3'b001;
    localparam logic [2:0] CSEL_L1   = 3'b011;
    localparam logic [2:0] CSEL_NONE = 3'b000;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CONV,
        ST_FLUSH,
        ST_POOL,
        ST_DONE,
        ST_ERR
    } state_e;
endpackage

// File: rtl/cnn_mem_port_mux.sv
// Steers the active engine's strobes, addresses and data onto the shared layer-memory port.
module cnn_mem_port_mux #(
    parameter int         ADDR_W  = cnn_pkg::ADDR_W,
    parameter int         DATA_W  = cnn_pkg::DATA_W,
    parameter logic [2:0] CSEL_L0 = cnn_pkg::CSEL_L0,
    parameter logic [2:0] CSEL_L1 = cnn_pkg::CSEL_L1
) (
    input  cnn_pkg::state_e    state,
    input  logic               conv_cwr,
    input  logic [ADDR_W:0]    conv_caddr,
    input  logic [DATA_W-1:0]  conv_cdata,
    input  logic               pool_crd,
    input  logic [ADDR_W-1:0]  pool_raddr,
    input  logic               pool_cwr,
    input  logic [ADDR_W-1:0]  pool_waddr,
    input  logic [DATA_W-1:0]  pool_wdata,
    output logic               cwr,
    output logic [ADDR_W-1:0]  caddr_wr,
    output logic [DATA_W-1:0]  cdata_wr,
    output logic               crd,
    output logic [ADDR_W-1:0]  caddr_rd,
    output logic [2:0]         csel,
    output logic               rw_conflict
);
    import cnn_pkg::*;

    always_comb begin
        cwr         = 1'b0;
        caddr_wr    = '0;
        cdata_wr    = '0;
        crd         = 1'b0;
        caddr_rd    = '0;
        csel        = CSEL_NONE;
        rw_conflict = 1'b0;
        case (state)
            ST_CONV: begin
                // sign bit set means the engine's pre-roll beat; never let it reach memory
                csel     = CSEL_L0;
                cwr      = conv_cwr & ~conv_caddr[ADDR_W];
                caddr_wr = conv_caddr[ADDR_W-1:0];
                cdata_wr = conv_cdata;
            end
            ST_POOL: begin
                rw_conflict = pool_cwr & pool_crd;
                if (pool_cwr) begin
                    cwr      = 1'b1;
                    caddr_wr = pool_waddr;
                    cdata_wr = pool_wdata;
                    csel     = CSEL_L1;
                end else if (pool_crd) begin
                    crd      = 1'b1;
                    caddr_rd = pool_raddr;
                    csel     = CSEL_L0;
                end
            end
            default: ;
        endcase
    end
endmodule

// File: rtl/cnn_layer_sequencer.sv
// Conv-then-pool phase sequencer with per-phase watchdog; owns the shared layer-memory port.
module cnn_layer_sequencer #(
    parameter int         ADDR_W  = cnn_pkg::ADDR_W,
    parameter int         DATA_W  = cnn_pkg::DATA_W,
    parameter int         TIMEOUT = 65535,
    parameter logic [2:0] CSEL_L0 = cnn_pkg::CSEL_L0,
    parameter logic [2:0] CSEL_L1 = cnn_pkg::CSEL_L1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               ready,
    output logic               busy,
    output logic               error,
    output logic               conv_start,
    input  logic               conv_finish,
    input  logic               conv_cwr,
    input  logic [ADDR_W:0]    conv_caddr,
    input  logic [DATA_W-1:0]  conv_cdata,
    output logic               pool_start,
    input  logic               pool_finish,
    input  logic               pool_crd,
    input  logic [ADDR_W-1:0]  pool_raddr,
    input  logic               pool_cwr,
    input  logic [ADDR_W-1:0]  pool_waddr,
    input  logic [DATA_W-1:0]  pool_wdata,
    output logic               cwr,
    output logic [ADDR_W-1:0]  caddr_wr,
    output logic [DATA_W-1:0]  cdata_wr,
    output logic               crd,
    output logic [ADDR_W-1:0]  caddr_rd,
    output logic [2:0]         csel,
    input  logic [DATA_W-1:0]  cdata_rd,
    output logic [DATA_W-1:0]  pool_rdata
);
    import cnn_pkg::*;

    localparam int               CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             error_q, error_d;
    logic             busy_q, busy_d;
    logic             conv_start_q, conv_start_d;
    logic             pool_start_q, pool_start_d;
    logic             rw_conflict;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            error_q      <= 1'b0;
            busy_q       <= 1'b0;
            conv_start_q <= 1'b0;
            pool_start_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            error_q      <= error_d;
            busy_q       <= busy_d;
            conv_start_q <= conv_start_d;
            pool_start_q <= pool_start_d;
        end
    end

    // Finish is tested before the watchdog so a finish on the last allowed cycle still completes.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        error_d = error_q;
        case (state_q)
            ST_IDLE: begin
                if (ready) begin
                    state_d = ST_CONV;
                    cnt_d   = '0;
                end
            end
            ST_CONV: begin
                if (conv_finish) begin
                    state_d = ST_FLUSH;
                end else if (cnt_q == LIMIT) begin
                    state_d = ST_ERR;
                    error_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_FLUSH: begin
                state_d = ST_POOL;
                cnt_d   = '0;
            end
            ST_POOL: begin
                if (rw_conflict) error_d = 1'b1;
                if (pool_finish) begin
                    state_d = ST_DONE;
                end else if (cnt_q == LIMIT) begin
                    state_d = ST_ERR;
                    error_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_DONE: state_d = ST_IDLE;
            ST_ERR: begin
                if (ready) begin
                    state_d = ST_CONV;
                    cnt_d   = '0;
                    error_d = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        busy_d       = (state_d == ST_CONV) || (state_d == ST_FLUSH) || (state_d == ST_POOL);
        conv_start_d = (state_d == ST_CONV);
        pool_start_d = (state_d == ST_POOL);
    end

    assign busy       = busy_q;
    assign error      = error_q;
    assign conv_start = conv_start_q;
    assign pool_start = pool_start_q;
    assign pool_rdata = cdata_rd;

    cnn_mem_port_mux #(
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .CSEL_L0 (CSEL_L0),
        .CSEL_L1 (CSEL_L1)
    ) u_mem_port_mux (
        .state       (state_q),
        .conv_cwr    (conv_cwr),
        .conv_caddr  (conv_caddr),
        .conv_cdata  (conv_cdata),
        .pool_crd    (pool_crd),
        .pool_raddr  (pool_raddr),
        .pool_cwr    (pool_cwr),
        .pool_waddr  (pool_waddr),
        .pool_wdata  (pool_wdata),
        .cwr         (cwr),
        .caddr_wr    (caddr_wr),
        .cdata_wr    (cdata_wr),
        .crd         (crd),
        .caddr_rd    (caddr_rd),
        .csel        (csel),
        .rw_conflict (rw_conflict)
    );
endmodule
